// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_add_unit_if.sv
// Start/busy/done handshake plus operand and result bus of the serial adder.
interface serial_add_unit_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             p_all;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow, p_all
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow, p_all
  );

endinterface

// File: rtl/adder_1bit.sv
// One-bit full-adder cell with generate/propagate outputs.
module adder_1bit (
  input  logic ai,
  input  logic bi,
  input  logic ci,
  output logic si,
  output logic co,
  output logic Gi,
  output logic Pi
);

  assign Gi = ai & bi;
  assign Pi = ai ^ bi;
  assign si = Pi ^ ci;
  assign co = Gi | (Pi & ci);

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, one operand bit pair per cycle,
// result and flags registered on the transition into DONE.
module serial_add_unit
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_unit_if.slave   bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             accept_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] sum_sr_r;
  logic             carry_r;
  logic [CW-1:0]    count_r;
  logic             p_acc_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             overflow_r;
  logic             p_all_r;

  logic             si_s;
  logic             co_s;
  logic             pi_s;
  logic             gi_unused;

  adder_1bit u_fa (
    .ai (a_sr_r[0]),
    .bi (b_sr_r[0]),
    .ci (carry_r),
    .si (si_s),
    .co (co_s),
    .Gi (gi_unused),
    .Pi (pi_s)
  );

  // Next-state decode; start only takes effect in IDLE or DONE.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = SHIFT;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (count_r == LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nxt_s = SHIFT;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, shift datapath and registered result/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      a_sr_r     <= '0;
      b_sr_r     <= '0;
      sum_sr_r   <= '0;
      carry_r    <= 1'b0;
      count_r    <= '0;
      p_acc_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      sum_r      <= '0;
      cout_r     <= 1'b0;
      overflow_r <= 1'b0;
      p_all_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == SHIFT);
      done_r  <= (state_nxt_s == DONE);
      if (accept_s) begin
        a_sr_r  <= bus.a;
        b_sr_r  <= bus.b;
        carry_r <= bus.cin;
        count_r <= '0;
        p_acc_r <= 1'b1;
      end else if (state_r == SHIFT) begin
        a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
        b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
        sum_sr_r <= {si_s, sum_sr_r[WIDTH-1:1]};
        carry_r  <= co_s;
        p_acc_r  <= p_acc_r & pi_s;
        count_r  <= count_r + CW'(1);
        // carry_r is the carry into the MSB while the last bit is processed
        if (count_r == LAST) begin
          sum_r      <= {si_s, sum_sr_r[WIDTH-1:1]};
          cout_r     <= co_s;
          overflow_r <= carry_r ^ co_s;
          p_all_r    <= p_acc_r & pi_s;
        end
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.sum      = sum_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = overflow_r;
  assign bus.p_all    = p_all_r;

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed and table-driven bench for serial_add_unit at WIDTH=8.
module tb_serial_add_unit;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_add_unit_if #(.WIDTH(W)) bus ();

  serial_add_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       pall;
  } vec_t;

  vec_t       vecs [10];
  int         checks = 0;
  int         errors = 0;
  int         lat;
  int         bcnt;
  int         seen;
  logic [7:0] ra;
  logic [7:0] rb;
  logic       rc;
  logic [8:0] full;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called on the negedge right after the accepting edge; lat = cycles to done.
  task automatic wait_done(input int poke_at, output int l, output int bc);
    l  = -1;
    bc = 0;
    for (int i = 0; i < 4 * W; i++) begin
      if (i == poke_at) begin
        bus.start = 1'b1;
        bus.a     = 8'h11;
      end else if (poke_at >= 0 && i == poke_at + 1) begin
        bus.start = 1'b0;
      end
      if (bus.busy) bc++;
      if (bus.done) begin
        l = i;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] esum, input logic ecout, input logic eovf,
                         input logic epall, input string tag, input int poke_at);
    int l;
    int bc;
    start_op(a, b, cin);
    wait_done(poke_at, l, bc);
    check({tag, "_latency"}, 32'(l), 32'(W));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(W));
    check({tag, "_sum"}, 32'(bus.sum), 32'(esum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(ecout));
    check({tag, "_overflow"}, 32'(bus.overflow), 32'(eovf));
    check({tag, "_p_all"}, 32'(bus.p_all), 32'(epall));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.cin   = 1'b0;
    #2;
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_p_all", 32'(bus.p_all), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
              vecs[i].ovf, vecs[i].pall, $sformatf("vec%0d", i), -1);
    end

    // start pulsed mid-SHIFT with a different operand must be ignored
    run_vec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "ignore_start", 2);

    // back-to-back with start held high; second operands captured in DONE
    @(negedge clk);
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.a = 8'h7F;
    bus.b = 8'h01;
    wait_done(-1, lat, bcnt);
    check("b2b_first_latency", 32'(lat), 32'(W));
    check("b2b_first_sum", 32'(bus.sum), 32'h03);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_no_gap_busy", 32'(bus.busy), 32'd1);
    wait_done(-1, lat, bcnt);
    check("b2b_second_latency", 32'(lat), 32'(W));
    check("b2b_second_sum", 32'(bus.sum), 32'h80);
    check("b2b_second_overflow", 32'(bus.overflow), 32'd1);
    check("b2b_second_cout", 32'(bus.cout), 32'd0);

    // reset in the middle of SHIFT clears outputs at once and suppresses done
    start_op(8'hAA, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_sum", 32'(bus.sum), 32'd0);
    check("midrst_overflow", 32'(bus.overflow), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (2 * W) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    run_vec(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, "post_rst", -1);

    for (int i = 0; i < 40; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      run_vec(ra, rb, rc, full[7:0], full[8],
              (ra[7] == rb[7]) && (full[7] != ra[7]), &(ra ^ rb),
              $sformatf("rnd%0d", i), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
